flat_to_array_row_streamer: RTL and testbench

Inverse of the team's array-to-flat packer. It accepts one flattened ROWS x COLS array word over a valid/ready handshake and holds it in a buffer. It then streams the array out one row per beat, as an unpacked array of COLS elements, over a second valid/ready handshake. It sits between wide flat datapaths (memories, packed buses) and row-oriented consumers such as MAC rows and systolic feeds.

---
 rtl/flat_array_pkg.sv | 10 +
 rtl/flat_row_slice.sv | 25 ++
 rtl/flat_to_array_row_streamer.sv | 70 +++++++
 tb/tb_flat_to_array_row_streamer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/flat_array_pkg.sv
// flat_array_pkg: flat-array layout helper, streamer FSM states and row-counter width
package flat_array_pkg;
  typedef enum logic {IDLE, EMIT} state_t;
  function automatic int elem_offset(input int r, input int c, input int rows, input int bit_width);
    return (c * rows + r) * bit_width;
  endfunction
  function automatic int cnt_w(input int rows);
    return rows > 1 ? $clog2(rows) : 1;
  endfunction
endpackage

// File: rtl/flat_row_slice.sv
// flat_row_slice: combinational pick of one COLS-element row out of a flat column-major array word
module flat_row_slice
  import flat_array_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int IW = cnt_w(ROWS)
) (
  input  logic [ROWS*COLS*BIT_WIDTH-1:0] data,
  input  logic [IW-1:0]                  idx,
  output logic [BIT_WIDTH-1:0]           row [COLS-1:0]
);
  logic [BIT_WIDTH-1:0] grid [ROWS-1:0][COLS-1:0];
  for (genvar r = 0; r < ROWS; r++) begin : g_r
    for (genvar c = 0; c < COLS; c++) begin : g_c
      assign grid[r][c] = data[elem_offset(r, c, ROWS, BIT_WIDTH) +: BIT_WIDTH];
    end
  end
  // Row mux; an out-of-range index falls back to row 0
  always_comb begin
    row = grid[0];
    for (int r = 1; r < ROWS; r++) row = idx == IW'(r) ? grid[r] : row;
  end
endmodule

// File: rtl/flat_to_array_row_streamer.sv
// flat_to_array_row_streamer: accepts a flat ROWS x COLS word, streams it one row per beat (optional m_array via FLAT_UNPACK_FULL_ARRAY_OUT_EN)
module flat_to_array_row_streamer
  import flat_array_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int IW = cnt_w(ROWS),
  localparam int W = ROWS * COLS * BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [W-1:0]         s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [BIT_WIDTH-1:0] m_row [COLS-1:0],
  output logic [IW-1:0]        m_row_idx,
  output logic                 m_last
`ifdef FLAT_UNPACK_FULL_ARRAY_OUT_EN
  , output logic [BIT_WIDTH-1:0] m_array [ROWS-1:0][COLS-1:0]
`endif
);
  state_t state, state_nx;
  logic [W-1:0] hold;
  logic [IW-1:0] idx;
  logic take, beat;
  assign m_valid = state == EMIT;
  assign m_last = m_valid && idx == IW'(ROWS - 1);
  assign s_ready = rst_n && (state == IDLE || (m_valid && m_ready && m_last));
  assign take = s_valid && s_ready;
  assign beat = m_valid && m_ready;
  assign m_row_idx = idx;
  // A capture always lands in EMIT; the last beat without a new word returns to IDLE
  always_comb begin
    state_nx = take ? EMIT : (beat && m_last) ? IDLE : state;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // Holding register and row counter; counter wraps only through a capture or the return to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      idx <= '0;
    end else if (take) begin
      hold <= s_data;
      idx <= '0;
    end else if (beat) begin
      idx <= m_last ? '0 : idx + 1'b1;
    end
  end
  flat_row_slice #(.BIT_WIDTH(BIT_WIDTH), .ROWS(ROWS), .COLS(COLS), .IW(IW)) u_row (
    .data(hold),
    .idx (idx),
    .row (m_row)
  );
`ifdef FLAT_UNPACK_FULL_ARRAY_OUT_EN
  for (genvar r = 0; r < ROWS; r++) begin : g_arr
    flat_row_slice #(.BIT_WIDTH(BIT_WIDTH), .ROWS(ROWS), .COLS(COLS), .IW(IW)) u_slice (
      .data(hold),
      .idx (IW'(r)),
      .row (m_array[r])
    );
  end
`endif
endmodule

// File: tb/tb_flat_to_array_row_streamer.sv
// tb_flat_to_array_row_streamer: scoreboard bench for a 2x2 and a 1x4 streamer sharing one source
module tb_flat_to_array_row_streamer;
  typedef struct {
    logic [15:0] row;
    int          idx;
    logic        last;
  } beat_t;
  logic clk = 0, rst_n = 0, s_valid = 0;
  logic [15:0] s_data = 0;
  logic [1:0] mr = 0, sr, mv, ml, mi;
  logic [3:0] row_a [1:0];
  logic [3:0] row_b [3:0];
  logic [15:0] rowp [2];
  beat_t sbq [2][$];
  logic [15:0] cur [2];
  int errors = 0, checks = 0;
`ifdef FLAT_UNPACK_FULL_ARRAY_OUT_EN
  logic [3:0] ma [1:0][1:0];
`endif

  always #5 clk = ~clk;

  flat_to_array_row_streamer #(.BIT_WIDTH(4), .ROWS(2), .COLS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sr[0]), .s_data(s_data),
    .m_valid(mv[0]), .m_ready(mr[0]), .m_row(row_a), .m_row_idx(mi[0]), .m_last(ml[0])
`ifdef FLAT_UNPACK_FULL_ARRAY_OUT_EN
    , .m_array(ma)
`endif
  );

  flat_to_array_row_streamer #(.BIT_WIDTH(4), .ROWS(1), .COLS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sr[1]), .s_data(s_data),
    .m_valid(mv[1]), .m_ready(mr[1]), .m_row(row_b), .m_row_idx(mi[1]), .m_last(ml[1])
`ifdef FLAT_UNPACK_FULL_ARRAY_OUT_EN
    , .m_array()
`endif
  );

  assign rowp[0] = {8'h00, row_a[1], row_a[0]};
  assign rowp[1] = {row_b[3], row_b[2], row_b[1], row_b[0]};

  function automatic int rows_of(input int k);
    return k == 0 ? 2 : 1;
  endfunction

  function automatic int cols_of(input int k);
    return k == 0 ? 2 : 4;
  endfunction

  // Row r of word w with element c of the row placed at nibble c
  function automatic logic [15:0] exp_row(input logic [15:0] w, input int rows, input int cols, input int r);
    logic [15:0] v;
    v = 0;
    for (int c = 0; c < cols; c++) v[c*4 +: 4] = w[(c*rows+r)*4 +: 4];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every cycle at the falling edge, pop on accepted beats, push on accepted words
  always @(negedge clk) begin
    int n;
    beat_t e;
`ifdef FLAT_UNPACK_FULL_ARRAY_OUT_EN
    if (!rst_n || mv[0])
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          chk($sformatf("m_array[%0d][%0d]", r, c), 32'(ma[r][c]), rst_n ? 32'(cur[0][(c*2+r)*4 +: 4]) : 32'd0);
`endif
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk($sformatf("rst_s_ready%0d", k), 32'(sr[k]), 0);
        chk($sformatf("rst_m_valid%0d", k), 32'(mv[k]), 0);
        chk($sformatf("rst_m_last%0d", k), 32'(ml[k]), 0);
        chk($sformatf("rst_idx%0d", k), 32'(mi[k]), 0);
        chk($sformatf("rst_row%0d", k), 32'(rowp[k]), 0);
        sbq[k].delete();
        cur[k] = 0;
      end else begin
        n = sbq[k].size();
        chk($sformatf("m_valid%0d", k), 32'(mv[k]), 32'(n != 0));
        chk($sformatf("s_ready%0d", k), 32'(sr[k]), 32'(n == 0 || (n == 1 && mr[k])));
        if (n != 0) begin
          e = sbq[k][0];
          chk($sformatf("row%0d", k), 32'(rowp[k]), 32'(e.row));
          chk($sformatf("idx%0d", k), 32'(mi[k]), e.idx);
          chk($sformatf("last%0d", k), 32'(ml[k]), 32'(e.last));
          if (mr[k]) void'(sbq[k].pop_front());
        end else begin
          chk($sformatf("idle_idx%0d", k), 32'(mi[k]), 0);
          chk($sformatf("idle_last%0d", k), 32'(ml[k]), 0);
          chk($sformatf("idle_row%0d", k), 32'(rowp[k]), 32'(exp_row(cur[k], rows_of(k), cols_of(k), 0)));
        end
        if (s_valid && sr[k]) begin
          for (int r = 0; r < rows_of(k); r++) begin
            e.row = exp_row(s_data, rows_of(k), cols_of(k), r);
            e.idx = r;
            e.last = r == rows_of(k) - 1;
            sbq[k].push_back(e);
          end
          cur[k] = s_data;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1 s_data = 16'hDCBA;
    s_valid = 1;
    mr = 2'b11;
    @(posedge clk);
    #1 s_valid = 0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      #1 s_valid = 1;
      s_data = i < 2 ? 16'hDCBA : i < 4 ? 16'h4321 : 16'($urandom);
      @(posedge clk);
    end
    #1 s_valid = 0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 600; i++) begin
      #1;
      if (i == 300) rst_n = 0;
      if (i == 303) rst_n = 1;
      s_valid = ($urandom % 3) != 0;
      s_data = 16'($urandom);
      mr = i < 100 ? 2'b11 : 2'($urandom);
      @(posedge clk);
    end
    #1 s_valid = 0;
    mr = 2'b11;
    for (int i = 0; i < 20 && (sbq[0].size() != 0 || sbq[1].size() != 0); i++) @(posedge clk);
    @(posedge clk);
    #1 chk("drain", sbq[0].size() + sbq[1].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
